// File: rtl/saboteur_fi_ctrl_pkg.sv
// Shared definitions for the saboteur fault-injection controllers and benches.
// State encodings, saboteur control codes and default geometry.
package saboteur_fi_ctrl_pkg;

  typedef enum logic [2:0] {
    FI_IDLE   = 3'd0,
    FI_SHIFT  = 3'd1,
    FI_INJECT = 3'd2,
    FI_CLEAR  = 3'd3,
    FI_DONE   = 3'd4
  } fi_state_e;

  // Saboteur 2-bit control codes; a transient is any code with bit 1 set.
  localparam logic [1:0] SA0   = 2'b00;
  localparam logic [1:0] SA1   = 2'b01;
  localparam logic [1:0] TRANS = 2'b10;

  localparam int WIDTH_SR_DEF = 131;
  localparam int POS_W_DEF    = 8;
  localparam int DUR_W_DEF    = 16;

  function automatic logic is_trans(input logic [1:0] code);
    return code[1];
  endfunction

endpackage

// File: rtl/saboteur_fi_ctrl_cnt.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
// Load takes priority over decrement.
module saboteur_fi_ctrl_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/saboteur_fi_ctrl.sv
// Saboteur scan-chain sequencer: shifts a one/two-hot chain image, holds TFEn
// for the programmed window, optionally flushes the chain with zeros.
module saboteur_fi_ctrl
  import saboteur_fi_ctrl_pkg::*;
#(
  parameter int WIDTH_SR = 131,
  parameter int POS_W    = 8,
  parameter int DUR_W    = 16
) (
  input  logic             i_CLK_x,
  input  logic             i_RST_x,
  input  logic             i_start,
  input  logic [POS_W-1:0] i_pos,
  input  logic             i_dbl,
  input  logic [DUR_W-1:0] i_dur,
  input  logic             i_autoclr,
  input  logic             i_stop,
  output logic             o_SI,
  output logic             o_EN_SR,
  output logic             o_TFEn,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam logic [POS_W-1:0] WIDTH_P = POS_W'(WIDTH_SR);
  localparam logic [POS_W-1:0] LAST_K  = POS_W'(WIDTH_SR - 1);
  localparam logic [POS_W:0]   WIDTH_X = (POS_W+1)'(WIDTH_SR);

  fi_state_e        state_reg, state_next;
  logic [POS_W-1:0] tgt_reg, tgt_next;
  logic             dbl_reg, dbl_next;
  logic             autoclr_reg, autoclr_next;
  logic             si_reg, si_next;
  logic             en_reg, en_next;
  logic             tfen_reg, tfen_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             err_reg, err_next;

  logic             sh_load, sh_dec, sh_zero;
  logic [POS_W-1:0] sh_cnt;
  logic             dur_load, dur_dec, dur_zero;
  logic [DUR_W-1:0] dur_cnt;
  logic [POS_W:0]   pos_x;
  logic             pos_bad;
  logic             inj_end;

  // Shift/clear counter holds the number of shifts still to come after the
  // one currently on the outputs.
  saboteur_fi_ctrl_cnt #(.W(POS_W)) u_sh_cnt (
    .clk      (i_CLK_x),
    .rst_n    (i_RST_x),
    .load     (sh_load),
    .load_val (LAST_K),
    .dec      (sh_dec),
    .cnt      (sh_cnt),
    .zero     (sh_zero)
  );

  // Loaded with the raw duration at accept; zero while injecting means hold mode.
  saboteur_fi_ctrl_cnt #(.W(DUR_W)) u_dur_cnt (
    .clk      (i_CLK_x),
    .rst_n    (i_RST_x),
    .load     (dur_load),
    .load_val (i_dur),
    .dec      (dur_dec),
    .cnt      (dur_cnt),
    .zero     (dur_zero)
  );

  assign pos_x   = {1'b0, i_pos};
  assign pos_bad = (pos_x >= WIDTH_X) || (i_dbl && ((pos_x + (POS_W+1)'(1)) >= WIDTH_X));

  always_comb begin
    state_next   = state_reg;
    tgt_next     = tgt_reg;
    dbl_next     = dbl_reg;
    autoclr_next = autoclr_reg;
    si_next      = 1'b0;
    en_next      = 1'b0;
    tfen_next    = 1'b0;
    done_next    = 1'b0;
    err_next     = 1'b0;
    sh_load      = 1'b0;
    sh_dec       = 1'b0;
    dur_load     = 1'b0;
    dur_dec      = 1'b0;
    inj_end      = 1'b0;

    case (state_reg)
      FI_IDLE: begin
        if (i_start) begin
          if (pos_bad) begin
            err_next = 1'b1;
          end else begin
            state_next   = FI_SHIFT;
            // Target is the counter value one cycle before bit pos goes out.
            tgt_next     = WIDTH_P - i_pos;
            dbl_next     = i_dbl;
            autoclr_next = i_autoclr;
            sh_load      = 1'b1;
            dur_load     = 1'b1;
            en_next      = 1'b1;
            si_next      = (i_pos == '0);
          end
        end
      end

      FI_SHIFT: begin
        if (sh_zero) begin
          state_next = FI_INJECT;
          tfen_next  = 1'b1;
        end else begin
          sh_dec  = 1'b1;
          en_next = 1'b1;
          si_next = (sh_cnt == tgt_reg) ||
                    (dbl_reg && ((sh_cnt + POS_W'(1)) == tgt_reg));
        end
      end

      FI_INJECT: begin
        inj_end = i_stop || (!dur_zero && (dur_cnt == DUR_W'(1)));
        dur_dec = 1'b1;
        if (inj_end) begin
          if (autoclr_reg) begin
            state_next = FI_CLEAR;
            sh_load    = 1'b1;
            en_next    = 1'b1;
          end else begin
            state_next = FI_DONE;
            done_next  = 1'b1;
          end
        end else begin
          tfen_next = 1'b1;
        end
      end

      FI_CLEAR: begin
        if (sh_zero) begin
          state_next = FI_DONE;
          done_next  = 1'b1;
        end else begin
          sh_dec  = 1'b1;
          en_next = 1'b1;
        end
      end

      FI_DONE: begin
        state_next = FI_IDLE;
      end

      default: begin
        state_next = FI_IDLE;
      end
    endcase

    busy_next = (state_next != FI_IDLE);
  end

  always_ff @(posedge i_CLK_x or negedge i_RST_x) begin
    if (!i_RST_x) begin
      state_reg   <= FI_IDLE;
      tgt_reg     <= '0;
      dbl_reg     <= 1'b0;
      autoclr_reg <= 1'b0;
      si_reg      <= 1'b0;
      en_reg      <= 1'b0;
      tfen_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tgt_reg     <= tgt_next;
      dbl_reg     <= dbl_next;
      autoclr_reg <= autoclr_next;
      si_reg      <= si_next;
      en_reg      <= en_next;
      tfen_reg    <= tfen_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign o_SI    = si_reg;
  assign o_EN_SR = en_reg;
  assign o_TFEn  = tfen_reg;
  assign o_busy  = busy_reg;
  assign o_done  = done_reg;
  assign o_err   = err_reg;

endmodule

// File: tb/tb_saboteur_fi_ctrl.sv
// Scoreboard bench for saboteur_fi_ctrl: driver queues expected sequences,
// monitor rebuilds each sequence from the pins and compares on done/err.
module tb_saboteur_fi_ctrl;
  localparam int W  = 131;
  localparam int PW = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pos = '0;
  logic          dbl = 1'b0;
  logic [DW-1:0] dur = '0;
  logic          autoclr = 1'b0;
  logic          stop = 1'b0;
  logic          si, en, tfen, busy, done, err;

  saboteur_fi_ctrl #(.WIDTH_SR(W), .POS_W(PW), .DUR_W(DW)) dut (
    .i_CLK_x   (clk),
    .i_RST_x   (rst_n),
    .i_start   (start),
    .i_pos     (pos),
    .i_dbl     (dbl),
    .i_dur     (dur),
    .i_autoclr (autoclr),
    .i_stop    (stop),
    .o_SI      (si),
    .o_EN_SR   (en),
    .o_TFEn    (tfen),
    .o_busy    (busy),
    .o_done    (done),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_err;
    int t;
    int pos;
    bit dbl;
    int len;
    bit autoclr;
  } exp_t;

  exp_t q[$];
  int   issued = 0;
  int   resp_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor capture state
  bit [W-1:0] chain_m = '0;
  int en1_len = 0, en2_len = 0, en_first = -1, tf_first = -1, tf_len = 0;
  bit seen_tf = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      en1_len = 0; en2_len = 0; en_first = -1; tf_first = -1; tf_len = 0; seen_tf = 1'b0;
    end else begin
      chk("en_tfen_overlap", longint'(en && tfen), 0);
      chk("si_without_en", longint'(!en && si), 0);
      if (en) begin
        chain_m = {si, chain_m[W-1:1]};
        if (!seen_tf) begin
          if (en1_len == 0) en_first = cyc;
          en1_len++;
        end else begin
          en2_len++;
        end
      end
      if (tfen) begin
        if (!seen_tf) tf_first = cyc;
        seen_tf = 1'b1;
        tf_len++;
      end
      if (err || done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_response: got err=%0b done=%0b, required no response", err, done);
        end else begin
          exp_t e;
          bit [W-1:0] exp_c;
          e = q.pop_front();
          if (e.is_err) begin
            chk("err_pulse", longint'(err), 1);
            chk("err_cycle", cyc, e.t);
            chk("err_busy", longint'(busy), 0);
            chk("err_no_shift", en1_len, 0);
            $display("txn %0d: reject pos=%0d dbl=%0b err at cycle %0d", resp_cnt, e.pos, e.dbl, cyc);
          end else begin
            exp_c = '0;
            if (!e.autoclr) begin
              exp_c[e.pos] = 1'b1;
              if (e.dbl) exp_c[e.pos+1] = 1'b1;
            end
            chk("done_pulse", longint'(done), 1);
            chk("en_first", en_first, e.t);
            chk("shift_len", en1_len, W);
            chk("tf_first", tf_first, e.t + W);
            chk("tf_len", tf_len, e.len);
            chk("clear_len", en2_len, e.autoclr ? W : 0);
            chk("done_cycle", cyc, e.t + W + e.len + (e.autoclr ? W : 0));
            chk("chain_bad_bits", $countones(chain_m ^ exp_c), 0);
            $display("txn %0d: pos=%0d dbl=%0b autoclr=%0b tfen_len=%0d (exp %0d) done at cycle %0d",
                     resp_cnt, e.pos, e.dbl, e.autoclr, tf_len, e.len, cyc);
          end
        end
        resp_cnt++;
        en1_len = 0; en2_len = 0; en_first = -1; tf_first = -1; tf_len = 0; seen_tf = 1'b0;
      end
    end
  end

  // stop_n: 0 = no stop, else stop sampled in the stop_n-th TFEn cycle
  task automatic issue(input int p, input bit d, input int du, input bit ac,
                       input int stop_n, input bit repulse);
    exp_t e;
    int   k;
    @(negedge clk);
    pos = PW'(p); dbl = d; dur = DW'(du); autoclr = ac; start = 1'b1;
    e.t       = cyc + 1;
    e.pos     = p;
    e.dbl     = d;
    e.autoclr = ac;
    e.is_err  = (p >= W) || (d && (p + 1 >= W));
    if (du == 0)                           e.len = stop_n;
    else if (stop_n > 0 && stop_n < du)    e.len = stop_n;
    else                                   e.len = du;
    q.push_back(e);
    issued++;
    @(negedge clk);
    start = 1'b0;
    pos = PW'($urandom); dbl = 1'($urandom); dur = DW'($urandom); autoclr = 1'($urandom);
    if (repulse && !e.is_err) begin
      repeat (20) @(negedge clk);
      pos = PW'($urandom_range(0, W - 2)); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (stop_n > 0 && !e.is_err) begin
      k = 0;
      while (!tfen && k < 400) begin
        @(negedge clk);
        k++;
      end
      chk("tfen_wait_timeout", longint'(k < 400), 1);
      repeat (stop_n - 1) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    k = 0;
    while (resp_cnt < issued && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("response_timeout", longint'(resp_cnt >= issued), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {si, en, tfen, busy, done, err}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(83, 0, 3, 0, 0, 0);
    issue(12, 1, 5, 1, 0, 0);
    issue(50, 0, 0, 0, 40, 0);
    issue(131, 0, 5, 0, 0, 0);
    issue(130, 1, 5, 0, 0, 0);
    issue(130, 0, 2, 0, 0, 0);
    issue(0, 1, 1, 1, 0, 0);
    issue(129, 1, 2, 0, 0, 0);
    issue(20, 0, 5, 0, 5, 0);
    issue(30, 0, 8, 0, 3, 1);
    issue(40, 0, 4, 0, 0, 1);

    // Reset in the middle of a shift
    @(negedge clk);
    pos = 8'd60; dbl = 1'b0; dur = 16'd3; autoclr = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("busy_mid_shift", longint'(busy && en), 1);
    #2 rst_n = 1'b0;
    #1 chk("outputs_after_async_reset", {si, en, tfen, busy, done, err}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(60, 0, 3, 1, 0, 0);

    for (int i = 0; i < 15; i++) begin
      int p, du, sn;
      bit d, ac;
      p  = $urandom_range(0, 135);
      d  = 1'($urandom);
      ac = 1'($urandom);
      du = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      if (du == 0) sn = $urandom_range(1, 30);
      else         sn = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 25) : 0;
      issue(p, d, du, ac, sn, 1'($urandom_range(0, 3) == 0));
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
